// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle CPU sequencing controller.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ADD   = 3'b000;
  localparam logic [2:0] SUB   = 3'b001;
  localparam logic [2:0] RTYPE = 3'b010;
  localparam logic [2:0] LUI   = 3'b100;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALU_B_RT      = 2'd0;
  localparam logic [1:0] ALU_B_FOUR    = 2'd1;
  localparam logic [1:0] ALU_B_IMM     = 2'd2;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the controller and memory.
interface multicycle_ctrl_if;
  logic mem_req_o;
  logic mem_we_o;
  logic iord_o;
  logic mem_ready_i;

  modport master (output mem_req_o, output mem_we_o, output iord_o, input mem_ready_i);
  modport slave  (input mem_req_o, input mem_we_o, input iord_o, output mem_ready_i);
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter: clears, counts stalled cycles, flags expiry at TIMEOUT.
module mc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  // Any cycle that is not a stalled access leaves the counter at zero.
  always_comb begin
    cnt_d = '0;
    if (inc_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller stepping each instruction through FETCH..WB.
//   state    | meaning
//   FETCH    | read instruction at PC, load IR, PC <= PC+4
//   DECODE   | precompute branch target in ALU
//   EXEC     | opcode-specific ALU op, branch/jump resolve
//   MEM      | data access at ALU-out address (lw/sw)
//   WB       | register-file write
//   HALT     | stopped after memory timeout, reset only exit
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    mem,
  input  logic [5:0]           opcode_i,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic                 pc_write_cond_o,
  output logic [1:0]           pc_src_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic                 reg_write_o,
  output logic                 illegal_o,
  output logic                 bus_err_o,
  output logic                 halted_o,
  output logic [CNT_W-1:0]     retired_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               timer_inc;
  logic               timer_expired;

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .inc_i     (timer_inc),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    timer_inc       = 1'b0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.iord_o      = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = PC_SRC_SEQ;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = ALU_B_RT;
    alu_op_o        = ADD;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    illegal_o       = 1'b0;
    bus_err_o       = 1'b0;
    halted_o        = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b_o = ALU_B_FOUR;
        // A ready in the expiry cycle still counts as a completed fetch.
        if (mem.mem_ready_i) begin
          mem.mem_req_o = 1'b1;
          ir_write_o    = 1'b1;
          pc_write_o    = 1'b1;
          state_d       = S_DECODE;
        end else if (timer_expired) begin
          bus_err_o = 1'b1;
          state_d   = S_HALT;
        end else begin
          mem.mem_req_o = 1'b1;
          timer_inc     = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_o = ALU_B_IMM_SH2;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode_i)
          OP_RTYPE: begin
            alu_op_o = RTYPE;
            state_d  = S_WB;
          end
          OP_ADDI: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = ALU_B_IMM;
            state_d     = S_WB;
          end
          OP_LUI: begin
            alu_op_o = LUI;
            state_d  = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = ALU_B_IMM;
            state_d     = S_MEM;
          end
          OP_BEQ: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = SUB;
            pc_write_cond_o = 1'b1;
            pc_src_o        = PC_SRC_BRANCH;
            retire          = 1'b1;
          end
          OP_J: begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_SRC_JUMP;
            retire     = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      S_MEM: begin
        mem.iord_o = 1'b1;
        if (mem.mem_ready_i) begin
          mem.mem_req_o = 1'b1;
          mem.mem_we_o  = (opcode_i == OP_SW);
          if (opcode_i == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (timer_expired) begin
          bus_err_o = 1'b1;
          state_d   = S_HALT;
        end else begin
          mem.mem_req_o = 1'b1;
          mem.mem_we_o  = (opcode_i == OP_SW);
          timer_inc     = 1'b1;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (opcode_i == OP_RTYPE);
        mem_to_reg_o = (opcode_i == OP_LW);
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_HALT:  halted_o = 1'b1;
      default: state_d  = S_FETCH;
    endcase

    // Reset abandons any access in flight and silences every strobe.
    if (!rst_n) begin
      state_d         = S_FETCH;
      retire          = 1'b0;
      timer_inc       = 1'b0;
      mem.mem_req_o   = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.iord_o      = 1'b0;
      ir_write_o      = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_src_o        = PC_SRC_SEQ;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = ALU_B_RT;
      alu_op_o        = ADD;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_write_o     = 1'b0;
      illegal_o       = 1'b0;
      bus_err_o       = 1'b0;
      halted_o        = 1'b0;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control-word and retire-count checks.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode_i;
  logic        ir_write_o, pc_write_o, pc_write_cond_o;
  logic [1:0]  pc_src_o, alu_src_b_o;
  logic        alu_src_a_o;
  logic [2:0]  alu_op_o;
  logic        reg_dst_o, mem_to_reg_o, reg_write_o;
  logic        illegal_o, bus_err_o, halted_o;
  logic [31:0] retired_o;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .mem             (bus),
    .opcode_i        (opcode_i),
    .ir_write_o      (ir_write_o),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .pc_src_o        (pc_src_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_write_o     (reg_write_o),
    .illegal_o       (illegal_o),
    .bus_err_o       (bus_err_o),
    .halted_o        (halted_o),
    .retired_o       (retired_o)
  );

  always #5 clk_i = ~clk_i;

  // {req we iord irw pcw pcwc}_{pc_src}_{a}_{b}_{aluop}_{rd m2r rw ill berr halt}
  logic [19:0] sig;
  assign sig = {bus.mem_req_o, bus.mem_we_o, bus.iord_o, ir_write_o, pc_write_o,
                pc_write_cond_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o, bus_err_o, halted_o};

  localparam logic [19:0] ZERO   = 20'b000000_00_0_00_000_000000;
  localparam logic [19:0] F_WAIT = 20'b100000_00_0_01_000_000000;
  localparam logic [19:0] F_RDY  = 20'b100110_00_0_01_000_000000;
  localparam logic [19:0] F_TO   = 20'b000000_00_0_01_000_000010;
  localparam logic [19:0] DEC    = 20'b000000_00_0_11_000_000000;
  localparam logic [19:0] EX_R   = 20'b000000_00_0_00_010_000000;
  localparam logic [19:0] EX_ADD = 20'b000000_00_1_10_000_000000;
  localparam logic [19:0] EX_LUI = 20'b000000_00_0_00_100_000000;
  localparam logic [19:0] EX_BEQ = 20'b000001_01_1_00_001_000000;
  localparam logic [19:0] EX_J   = 20'b000010_10_0_00_000_000000;
  localparam logic [19:0] EX_ILL = 20'b000000_00_0_00_000_000100;
  localparam logic [19:0] MEM_LW = 20'b101000_00_0_00_000_000000;
  localparam logic [19:0] MEM_SW = 20'b111000_00_0_00_000_000000;
  localparam logic [19:0] WB_R   = 20'b000000_00_0_00_000_101000;
  localparam logic [19:0] WB_LW  = 20'b000000_00_0_00_000_011000;
  localparam logic [19:0] WB_I   = 20'b000000_00_0_00_000_001000;
  localparam logic [19:0] HALT   = 20'b000000_00_0_00_000_000001;

  // Check the control word for the current cycle, then advance one clock.
  task automatic step(input string tag, input logic [19:0] exp);
    #1;
    checks++;
    assert (sig === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, sig, exp);
      end
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_ret(input string tag, input logic [31:0] exp);
    #1;
    checks++;
    assert (retired_o === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, retired_o, exp);
      end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n           = 1'b0;
    opcode_i        = 6'h00;
    bus.mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    step("reset_gated", ZERO);
    rst_n = 1'b1;
    chk_ret("reset_retired", 32'd0);

    opcode_i = 6'h00;
    step("add_fetch", F_RDY);
    step("add_decode", DEC);
    step("add_exec", EX_R);
    step("add_wb", WB_R);
    chk_ret("add_retired", 32'd1);

    opcode_i = 6'h23;
    bus.mem_ready_i = 1'b0;
    step("lw_fetch_w1", F_WAIT);
    step("lw_fetch_w2", F_WAIT);
    bus.mem_ready_i = 1'b1;
    step("lw_fetch_rdy", F_RDY);
    step("lw_decode", DEC);
    step("lw_exec", EX_ADD);
    bus.mem_ready_i = 1'b0;
    step("lw_mem_w1", MEM_LW);
    step("lw_mem_w2", MEM_LW);
    bus.mem_ready_i = 1'b1;
    step("lw_mem_rdy", MEM_LW);
    step("lw_wb", WB_LW);
    chk_ret("lw_retired", 32'd2);

    opcode_i = 6'h2B;
    step("sw_fetch", F_RDY);
    step("sw_decode", DEC);
    step("sw_exec", EX_ADD);
    step("sw_mem", MEM_SW);
    chk_ret("sw_retired", 32'd3);
    opcode_i = 6'h04;
    step("beq_fetch", F_RDY);
    step("beq_decode", DEC);
    step("beq_exec", EX_BEQ);
    chk_ret("beq_retired", 32'd4);

    opcode_i = 6'h08;
    step("addi_fetch", F_RDY);
    step("addi_decode", DEC);
    step("addi_exec", EX_ADD);
    step("addi_wb", WB_I);
    chk_ret("addi_retired", 32'd5);
    opcode_i = 6'h02;
    step("j_fetch", F_RDY);
    step("j_decode", DEC);
    step("j_exec", EX_J);
    chk_ret("j_retired", 32'd6);
    opcode_i = 6'h0F;
    step("lui_fetch", F_RDY);
    step("lui_decode", DEC);
    step("lui_exec", EX_LUI);
    step("lui_wb", WB_I);
    chk_ret("lui_retired", 32'd7);

    opcode_i = 6'h3F;
    step("ill_fetch", F_RDY);
    step("ill_decode", DEC);
    step("ill_exec", EX_ILL);
    chk_ret("ill_retired", 32'd7);

    // Ready arriving exactly when the wait count hits TIMEOUT completes the fetch.
    opcode_i = 6'h02;
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) step("edge_wait", F_WAIT);
    bus.mem_ready_i = 1'b1;
    step("edge_fetch_rdy", F_RDY);
    step("edge_decode", DEC);
    step("edge_exec", EX_J);
    chk_ret("edge_retired", 32'd8);

    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) step("to_wait", F_WAIT);
    step("to_bus_err", F_TO);
    step("to_halt1", HALT);
    bus.mem_ready_i = 1'b1;
    step("to_halt2", HALT);
    step("to_halt3", HALT);
    chk_ret("to_retired", 32'd8);
    rst_n = 1'b0;
    step("to_reset", ZERO);
    rst_n = 1'b1;
    chk_ret("to_reset_retired", 32'd0);

    opcode_i = 6'h23;
    step("mr_fetch", F_RDY);
    step("mr_decode", DEC);
    step("mr_exec", EX_ADD);
    bus.mem_ready_i = 1'b0;
    step("mr_mem_wait", MEM_LW);
    rst_n = 1'b0;
    step("mr_reset_gated", ZERO);
    rst_n = 1'b1;
    bus.mem_ready_i = 1'b1;
    chk_ret("mr_retired", 32'd0);
    step("mr_fetch_after", F_RDY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
